// File: rtl/mouse_pos_pkg.sv
// rtl/mouse_pos_pkg.sv - shared state type and constants for the mouse position controller
package mouse_pos_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_WR_X = 2'd2,
        S_WR_Y = 2'd3
    } state_t;

    localparam logic [1:0] PIO_DATA_ADDR = 2'd0;
    localparam int DEF_POS_W = 12;
    localparam int DEF_X_MAX = 639;
    localparam int DEF_Y_MAX = 479;

endpackage

// File: rtl/mouse_axis_upd.sv
// rtl/mouse_axis_upd.sv - one-axis position update (clamp, or wrap with MOUSE_POS_CTRL_WRAP_EN)
module mouse_axis_upd #(
    parameter int POS_W = 12,
    parameter int MAX   = 639
) (
    input  logic [POS_W-1:0] i_pos,
    input  logic [7:0]       i_delta,
    output logic [POS_W-1:0] o_pos,
    output logic             o_changed
);

    localparam logic signed [POS_W+1:0] MAX_S = (POS_W+2)'(MAX);
    localparam logic signed [POS_W+1:0] MOD_S = (POS_W+2)'(MAX + 1);

    logic signed [POS_W+1:0] w_sum;
    logic signed [POS_W+1:0] w_res;

    assign w_sum = $signed({2'b00, i_pos}) + $signed({{(POS_W-6){i_delta[7]}}, i_delta});

    always_comb begin
        w_res = w_sum;
`ifdef MOUSE_POS_CTRL_WRAP_EN
        // |delta| never exceeds MAX+1, so one correction is always enough
        if (w_sum[POS_W+1])
            w_res = w_sum + MOD_S;
        else if (w_sum > MAX_S)
            w_res = w_sum - MOD_S;
`else
        if (w_sum[POS_W+1])
            w_res = '0;
        else if (w_sum > MAX_S)
            w_res = MAX_S;
`endif
    end

    assign o_pos     = w_res[POS_W-1:0];
    assign o_changed = (w_res != $signed({2'b00, i_pos}));

endmodule

// File: rtl/mouse_pos_ctrl.sv
// rtl/mouse_pos_ctrl.sv - tracks cursor position from mouse deltas and writes it to the X/Y PIOs
module mouse_pos_ctrl
    import mouse_pos_pkg::*;
#(
    parameter int POS_W = DEF_POS_W,
    parameter int X_MAX = DEF_X_MAX,
    parameter int Y_MAX = DEF_Y_MAX
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             delta_valid,
    output logic             delta_ready,
    input  logic [7:0]       delta_x,
    input  logic [7:0]       delta_y,
    input  logic             center_req,
    output logic [1:0]       pio_address,
    output logic             pio_cs_x,
    output logic             pio_cs_y,
    output logic             pio_write_n,
    output logic [31:0]      pio_writedata,
    output logic [POS_W-1:0] pos_x,
    output logic [POS_W-1:0] pos_y,
    output logic             busy
);

    localparam logic [POS_W-1:0] X_CTR = POS_W'(X_MAX / 2);
    localparam logic [POS_W-1:0] Y_CTR = POS_W'(Y_MAX / 2);

    state_t           r_state;
    logic [7:0]       r_dx;
    logic [7:0]       r_dy;
    logic             r_center;
    logic             r_chg_y;
    logic [POS_W-1:0] r_pos_x;
    logic [POS_W-1:0] r_pos_y;
    logic             r_cs_x;
    logic             r_cs_y;
    logic             r_write_n;
    logic [31:0]      r_wdata;

    logic [POS_W-1:0] w_ax_pos;
    logic [POS_W-1:0] w_ay_pos;
    logic             w_ax_chg;
    logic             w_ay_chg;
    logic [POS_W-1:0] w_nx;
    logic [POS_W-1:0] w_ny;
    logic             w_chg_x;
    logic             w_chg_y;

    mouse_axis_upd #(.POS_W(POS_W), .MAX(X_MAX)) u_axis_x (
        .i_pos     (r_pos_x),
        .i_delta   (r_dx),
        .o_pos     (w_ax_pos),
        .o_changed (w_ax_chg)
    );

    mouse_axis_upd #(.POS_W(POS_W), .MAX(Y_MAX)) u_axis_y (
        .i_pos     (r_pos_y),
        .i_delta   (r_dy),
        .o_pos     (w_ay_pos),
        .o_changed (w_ay_chg)
    );

    // A recentre always rewrites both PIOs, even when the value is unchanged
    assign w_nx    = r_center ? X_CTR : w_ax_pos;
    assign w_ny    = r_center ? Y_CTR : w_ay_pos;
    assign w_chg_x = r_center | w_ax_chg;
    assign w_chg_y = r_center | w_ay_chg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_dx      <= '0;
            r_dy      <= '0;
            r_center  <= 1'b0;
            r_chg_y   <= 1'b0;
            r_pos_x   <= '0;
            r_pos_y   <= '0;
            r_cs_x    <= 1'b0;
            r_cs_y    <= 1'b0;
            r_write_n <= 1'b1;
            r_wdata   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (center_req) begin
                        r_center <= 1'b1;
                        r_state  <= S_CALC;
                    end else if (delta_valid) begin
                        r_dx     <= delta_x;
                        r_dy     <= delta_y;
                        r_center <= 1'b0;
                        r_state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_pos_x <= w_nx;
                    r_pos_y <= w_ny;
                    r_chg_y <= w_chg_y;
                    if (w_chg_x) begin
                        r_state   <= S_WR_X;
                        r_cs_x    <= 1'b1;
                        r_write_n <= 1'b0;
                        r_wdata   <= {{(32-POS_W){1'b0}}, w_nx};
                    end else if (w_chg_y) begin
                        r_state   <= S_WR_Y;
                        r_cs_y    <= 1'b1;
                        r_write_n <= 1'b0;
                        r_wdata   <= {{(32-POS_W){1'b0}}, w_ny};
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_WR_X: begin
                    r_cs_x <= 1'b0;
                    if (r_chg_y) begin
                        r_state <= S_WR_Y;
                        r_cs_y  <= 1'b1;
                        r_wdata <= {{(32-POS_W){1'b0}}, r_pos_y};
                    end else begin
                        r_state   <= S_IDLE;
                        r_write_n <= 1'b1;
                        r_wdata   <= '0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_cs_y    <= 1'b0;
                    r_write_n <= 1'b1;
                    r_wdata   <= '0;
                end
            endcase
        end
    end

    assign delta_ready   = (r_state == S_IDLE) && !center_req && !reset;
    assign busy          = (r_state != S_IDLE);
    assign pio_address   = PIO_DATA_ADDR;
    assign pio_cs_x      = r_cs_x;
    assign pio_cs_y      = r_cs_y;
    assign pio_write_n   = r_write_n;
    assign pio_writedata = r_wdata;
    assign pos_x         = r_pos_x;
    assign pos_y         = r_pos_y;

endmodule

// File: tb/tb_mouse_pos_ctrl.sv
// tb/tb_mouse_pos_ctrl.sv - self-checking bench for mouse_pos_ctrl
module tb_mouse_pos_ctrl;

    localparam int XM = 639;
    localparam int YM = 479;

    logic        clk;
    logic        reset;
    logic        delta_valid;
    logic        delta_ready;
    logic [7:0]  delta_x;
    logic [7:0]  delta_y;
    logic        center_req;
    logic [1:0]  pio_address;
    logic        pio_cs_x;
    logic        pio_cs_y;
    logic        pio_write_n;
    logic [31:0] pio_writedata;
    logic [11:0] pos_x;
    logic [11:0] pos_y;
    logic        busy;

    int n_checks = 0;
    int n_err    = 0;
    int m_x      = 0;
    int m_y      = 0;

    mouse_pos_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .delta_valid   (delta_valid),
        .delta_ready   (delta_ready),
        .delta_x       (delta_x),
        .delta_y       (delta_y),
        .center_req    (center_req),
        .pio_address   (pio_address),
        .pio_cs_x      (pio_cs_x),
        .pio_cs_y      (pio_cs_y),
        .pio_write_n   (pio_write_n),
        .pio_writedata (pio_writedata),
        .pos_x         (pos_x),
        .pos_y         (pos_y),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int upd(input int pos, input int d, input int mx);
        int s;
        s = pos + d;
`ifdef MOUSE_POS_CTRL_WRAP_EN
        if (s < 0) s = s + mx + 1;
        else if (s > mx) s = s - (mx + 1);
`else
        if (s < 0) s = 0;
        else if (s > mx) s = mx;
`endif
        return s;
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_csx"}, pio_cs_x, 0);
        chk({tag, "_csy"}, pio_cs_y, 0);
        chk({tag, "_wn"}, pio_write_n, 1);
        chk({tag, "_wd"}, pio_writedata, 0);
    endtask

    // Called just after a falling edge; returns just after a falling edge with the DUT idle.
    task automatic run_cmd(input bit ctr, input int dx, input int dy);
        int nx, ny;
        bit cx, cy;
        logic [31:0] vx, vy;
        if (ctr) begin
            nx = XM / 2; ny = YM / 2; cx = 1; cy = 1;
        end else begin
            nx = upd(m_x, dx, XM); ny = upd(m_y, dy, YM);
            cx = (nx != m_x); cy = (ny != m_y);
        end
        vx = nx; vy = ny;
        if (ctr) center_req = 1'b1;
        else begin
            vx = dx; delta_x = vx[7:0];
            vy = dy; delta_y = vy[7:0];
            delta_valid = 1'b1;
            vx = nx; vy = ny;
        end
        #1;
        chk("ready_pre", delta_ready, ctr ? 0 : 1);
        @(posedge clk);
        @(negedge clk);
        center_req = 1'b0;
        delta_valid = 1'b0;
        #1;
        chk("calc_busy", busy, 1);
        chk("calc_ready", delta_ready, 0);
        chk("calc_cs", {pio_cs_x, pio_cs_y}, 0);
        if (cx) begin
            @(negedge clk); #1;
            chk("wrx_cs", {pio_cs_x, pio_cs_y}, 2);
            chk("wrx_wn", pio_write_n, 0);
            chk("wrx_data", pio_writedata, vx);
            chk("wrx_addr", pio_address, 0);
        end
        if (cy) begin
            @(negedge clk); #1;
            chk("wry_cs", {pio_cs_x, pio_cs_y}, 1);
            chk("wry_wn", pio_write_n, 0);
            chk("wry_data", pio_writedata, vy);
        end
        @(negedge clk); #1;
        chk_idle("done");
        chk("done_ready", delta_ready, 1);
        chk("pos_x", pos_x, vx);
        chk("pos_y", pos_y, vy);
        m_x = nx;
        m_y = ny;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_x = 0;
        m_y = 0;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        delta_valid = 1'b0;
        delta_x = '0;
        delta_y = '0;
        center_req = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_idle("rst");
        chk("rst_ready", delta_ready, 0);
        chk("rst_posx", pos_x, 0);
        chk("rst_posy", pos_y, 0);
        chk("rst_addr", pio_address, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;

        run_cmd(0, 10, 5);

        // reset during WR_X abandons the write
        @(negedge clk);
        delta_x = 8'd7; delta_y = 8'd7; delta_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        delta_valid = 1'b0;
        @(negedge clk); #1;
        chk("mid_csx", pio_cs_x, 1);
        reset = 1'b1;
        #1;
        chk_idle("mid_rst");
        chk("mid_ready", delta_ready, 0);
        chk("mid_posx", pos_x, 0);
        chk("mid_posy", pos_y, 0);
        @(negedge clk);
        reset = 1'b0;
        m_x = 0; m_y = 0;
        #1;
        run_cmd(0, 1, 1);

        // low boundary
        do_reset();
        run_cmd(0, -20, 0);
        run_cmd(0, 5, 0);
        run_cmd(0, -20, 0);
        do_reset();
        run_cmd(0, 3, 0);
        run_cmd(0, -20, 0);

        // high boundary
        do_reset();
        repeat (4) run_cmd(0, 127, 127);
        run_cmd(0, 122, -9);
        run_cmd(0, 127, 127);

        run_cmd(0, 0, 0);

        // centre beats a simultaneous delta, which is taken afterwards
        @(negedge clk);
        center_req = 1'b1;
        delta_valid = 1'b1; delta_x = 8'd5; delta_y = 8'hFD;
        #1;
        chk("ctr_ready", delta_ready, 0);
        @(posedge clk);
        @(negedge clk);
        center_req = 1'b0;
        #1;
        chk("ctr_calc_ready", delta_ready, 0);
        @(negedge clk); #1;
        chk("ctr_wrx", pio_writedata, 319);
        chk("ctr_wrx_cs", {pio_cs_x, pio_cs_y}, 2);
        @(negedge clk); #1;
        chk("ctr_wry", pio_writedata, 239);
        chk("ctr_wry_cs", {pio_cs_x, pio_cs_y}, 1);
        @(negedge clk); #1;
        chk("ctr_idle_ready", delta_ready, 1);
        chk("ctr_posx", pos_x, 319);
        m_x = 319; m_y = 239;
        run_cmd(0, 5, -3);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0)
                run_cmd(1, 0, 0);
            else
                run_cmd(0, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
